idct_coef_loader: RTL
=====================

# idct_coef_loader

- Upstream feeder for `Fast_IDCT`.
- Accepts one entropy-decoded coefficient per cycle in zig-zag scan order.
- Multiplies each coefficient by its quantisation-table entry and saturates the result to 16-bit signed.
- Writes the result into a natural-order 8×8 block register and presents the completed block as one 1024-bit word, already packed the way `Fast_IDCT.in` expects.
- Supports early end-of-block: all unsent positions are zero.

## Interface
Parameters:
- ML, 16, coefficient width; `blk_data` is ML*64 bits.
- QW, 8, quantiser entry width (unsigned).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- coef_valid  in  1  a coefficient is offered.
- coef_ready  out  1  loader can accept a coefficient.
- coef_data  in  ML  signed coefficient, zig-zag order.
- coef_eob  in  1  qualifies `coef_data`; marks the last coefficient of the block.
- qt_we  in  1  quant-table write strobe.
- qt_addr  in  6  table index, natural (row-major) order.
- qt_data  in  QW  unsigned quantiser value.
- blk_valid  out  1  complete block is presented.
- blk_ready  in  1  consumer takes the block.
- blk_data  out  ML*64  block; natural index n occupies bits [ML*n+ML-1 : ML*n]; n=0 is at the LSBs, row-major.

## Operation
- **State machine:** two states.
  - FILL: `coef_ready`=1, `blk_valid`=0.
  - OUT: `coef_ready`=0, `blk_valid`=1.
- **Scan counter:** 6-bit `idx`, reset 0. A coefficient is accepted on an edge where `coef_valid && coef_ready`.
- **On accept:**
  - n = ZZ[idx], the standard JPEG zig-zag table. It begins 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,… and ends …,55,62,63.
  - buf[n] = sat16(coef_data × qt[n]).
  - `idx` increments.
- **Block end:** if `idx`==63 or `coef_eob`=1, the next state is OUT and `idx` returns to 0.
- **Dequantisation arithmetic:**
  - Signed ML × zero-extended QW gives a full-precision (ML+QW+1)-bit product.
  - sat16 clamps to [-32768, 32767]; in-range products pass unchanged.
  - qt entry 0 produces 0.
- **Release:** on an edge in OUT with `blk_ready`=1:
  - all 64 `buf` entries clear to 0;
  - state returns to FILL.
- **Early end:** positions not written before `coef_eob` remain 0 in the presented block.
- **Quant table:**
  - 64×QW registers; all entries reset to 1, so by default coefficients pass through unchanged.
  - A write takes effect on the edge where `qt_we`=1 and is legal in any state.
  - If a coefficient accepted on the same edge uses the entry being written, it uses the old value.
- **`blk_data`:**
  - Driven directly from `buf`; it is stable for the whole OUT period.
  - In FILL it shows the partial block; the consumer must not sample it then.
- **`coef_eob` when `coef_valid`=0:** ignored.
- **Reset**, asynchronous and any time including mid-block:
  - state=FILL, `idx`=0, `buf` all 0, qt all 1;
  - outputs `coef_ready`=1, `blk_valid`=0, `blk_data`=0;
  - a partial block is discarded.

## Timing
- Full block: 64 accept edges in FILL. `blk_valid` rises in the cycle after the 64th accept.
- EOB block: `blk_valid` rises in the cycle after the accept carrying `coef_eob`.
- `coef_ready` falls in the same cycle `blk_valid` rises.
- A block persists until a `blk_ready` edge. `coef_ready` returns to 1 in the cycle after that edge, and `blk_valid`=0 in that cycle.
- Throughput with `blk_ready` held at 1 and `coef_valid` continuous: one full block every 65 cycles.
- `coef_ready` and `blk_valid` are register-derived, with no combinational path from the inputs.
  - `blk_ready` may therefore depend combinationally on `blk_valid`.
  - `coef_valid` may depend combinationally on `coef_ready`.
- Stalls are legal at any point: `coef_valid`=0 in FILL simply holds `idx`.

## Test plan
- **Pass-through:** after reset, send coefficients 1..64 (k-th value = k), `blk_ready`=1.
  - `blk_valid` is high exactly in cycle 65.
  - `blk_data` slot ZZ[k-1] = k; e.g. slot 0=1, slot 1=2, slot 8=3, slot 16=4, slot 63=64.
  - Back-to-back blocks arrive every 65 cycles.
- **Dequant and saturation:** write qt[0]=16, qt[1]=255, qt[8]=200. Send 100, -200, 300 with eob on the third.
  - Slot 0=1600, slot 1=-32768, slot 8=32767, all other slots 0.
  - `blk_valid` is high in the cycle after the eob accept.
- **EOB on first coefficient:** send 5 with eob.
  - Block has slot 0=5 and all others 0.
  - A following full block shows no residue from the earlier one.
- **Backpressure:** hold `blk_ready`=0 for 10 cycles after `blk_valid` rises.
  - `coef_ready` stays 0 and `blk_data` is unchanged.
  - Offered coefficients are not consumed.
  - When `blk_ready`=1, release happens on that edge and `coef_ready`=1 in the next cycle.
- **Table write race:** `qt_we` to addr 0 with value 3, in the same edge a coefficient of 7 is accepted at idx 0 (qt[0]=1).
  - Slot 0=7.
  - The next block's slot 0 with the same input is 21.
- **Reset mid-block:** accept 30 coefficients, then pulse `rst`.
  - Immediately `blk_valid`=0, `coef_ready`=1, `blk_data`=0, qt reverts to 1.
  - A fresh 64-coefficient block then completes normally in 65 cycles.

Source files
------------

// File: rtl/idct_coef_loader.sv
//------------------------------------------------------------------------------
// Module   : idct_coef_loader
// Brief    : Dequantises zig-zag coefficients into a natural-order 8x8 block
//            packed as one ML*64-bit word for the IDCT core.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module idct_coef_loader #(
    parameter int ML = 16,
    parameter int QW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            coef_valid,
    output logic            coef_ready,
    input  logic [ML-1:0]   coef_data,
    input  logic            coef_eob,
    input  logic            qt_we,
    input  logic [5:0]      qt_addr,
    input  logic [QW-1:0]   qt_data,
    output logic            blk_valid,
    input  logic            blk_ready,
    output logic [ML*64-1:0] blk_data
);

    localparam int c_PW = ML + QW + 1;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [5:0]             idx_q, idx_d;
    logic [63:0][ML-1:0]    buf_q;
    logic [63:0][QW-1:0]    qt_q;

    logic                   w_accept;
    logic                   w_release;
    logic [5:0]             w_nat;
    logic signed [c_PW-1:0] w_prod;
    logic signed [15:0]     w_sat;
    logic [ML-1:0]          w_val;

    // Zig-zag scan position -> natural row-major index.
    function automatic logic [5:0] f_zz(input logic [5:0] i);
        case (i)
            6'd0:  f_zz = 6'd0;   6'd1:  f_zz = 6'd1;   6'd2:  f_zz = 6'd8;   6'd3:  f_zz = 6'd16;
            6'd4:  f_zz = 6'd9;   6'd5:  f_zz = 6'd2;   6'd6:  f_zz = 6'd3;   6'd7:  f_zz = 6'd10;
            6'd8:  f_zz = 6'd17;  6'd9:  f_zz = 6'd24;  6'd10: f_zz = 6'd32;  6'd11: f_zz = 6'd25;
            6'd12: f_zz = 6'd18;  6'd13: f_zz = 6'd11;  6'd14: f_zz = 6'd4;   6'd15: f_zz = 6'd5;
            6'd16: f_zz = 6'd12;  6'd17: f_zz = 6'd19;  6'd18: f_zz = 6'd26;  6'd19: f_zz = 6'd33;
            6'd20: f_zz = 6'd40;  6'd21: f_zz = 6'd48;  6'd22: f_zz = 6'd41;  6'd23: f_zz = 6'd34;
            6'd24: f_zz = 6'd27;  6'd25: f_zz = 6'd20;  6'd26: f_zz = 6'd13;  6'd27: f_zz = 6'd6;
            6'd28: f_zz = 6'd7;   6'd29: f_zz = 6'd14;  6'd30: f_zz = 6'd21;  6'd31: f_zz = 6'd28;
            6'd32: f_zz = 6'd35;  6'd33: f_zz = 6'd42;  6'd34: f_zz = 6'd49;  6'd35: f_zz = 6'd56;
            6'd36: f_zz = 6'd57;  6'd37: f_zz = 6'd50;  6'd38: f_zz = 6'd43;  6'd39: f_zz = 6'd36;
            6'd40: f_zz = 6'd29;  6'd41: f_zz = 6'd22;  6'd42: f_zz = 6'd15;  6'd43: f_zz = 6'd23;
            6'd44: f_zz = 6'd30;  6'd45: f_zz = 6'd37;  6'd46: f_zz = 6'd44;  6'd47: f_zz = 6'd51;
            6'd48: f_zz = 6'd58;  6'd49: f_zz = 6'd59;  6'd50: f_zz = 6'd52;  6'd51: f_zz = 6'd45;
            6'd52: f_zz = 6'd38;  6'd53: f_zz = 6'd31;  6'd54: f_zz = 6'd39;  6'd55: f_zz = 6'd46;
            6'd56: f_zz = 6'd53;  6'd57: f_zz = 6'd60;  6'd58: f_zz = 6'd61;  6'd59: f_zz = 6'd54;
            6'd60: f_zz = 6'd47;  6'd61: f_zz = 6'd55;  6'd62: f_zz = 6'd62;
            default: f_zz = 6'd63;
        endcase
    endfunction

    assign coef_ready = (state_q == S_FILL);
    assign blk_valid  = (state_q == S_OUT);
    assign blk_data   = buf_q;

    assign w_accept  = coef_valid && (state_q == S_FILL);
    assign w_release = blk_ready && (state_q == S_OUT);

    // Quantiser is unsigned, so it is widened with a zero sign bit before the signed multiply.
    assign w_nat  = f_zz(idx_q);
    assign w_prod = c_PW'($signed(coef_data)) * c_PW'($signed({1'b0, qt_q[w_nat]}));

    always_comb begin
        w_sat = w_prod[15:0];
        if (w_prod > c_PW'(32767)) begin
            w_sat = 16'sh7FFF;
        end else if (w_prod < c_PW'(-32768)) begin
            w_sat = 16'sh8000;
        end
    end

    assign w_val = ML'(w_sat);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_FILL: begin
                if (w_accept) begin
                    idx_d = idx_q + 6'd1;
                    if ((idx_q == 6'd63) || coef_eob) begin
                        state_d = S_OUT;
                        idx_d   = 6'd0;
                    end
                end
            end
            S_OUT: begin
                if (blk_ready) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
            idx_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else if (w_release) begin
            buf_q <= '0;
        end else if (w_accept) begin
            buf_q[w_nat] <= w_val;
        end
    end

    // Written after the accept path reads it, so a same-edge write is seen by the next coefficient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                qt_q[i] <= QW'(1);
            end
        end else if (qt_we) begin
            qt_q[qt_addr] <= qt_data;
        end
    end

endmodule

`default_nettype wire
